// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: the raw keyboard pins go in, decoded bytes and fault reports come out.
interface ps2_frame_rx_if;
    logic       kbclk;
    logic       kbdat;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [1:0] err_type;
    logic       busy;

    // Keyboard/stimulus side: drives the pins and observes the results
    modport master (
        output kbclk,
        output kbdat,
        input  code,
        input  code_valid,
        input  frame_err,
        input  err_type,
        input  busy
    );

    // Receiver side
    modport slave (
        input  kbclk,
        input  kbdat,
        output code,
        output code_valid,
        output frame_err,
        output err_type,
        output busy
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters kbclk/kbdat, deserialises
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and reports faults.
// Everything runs on clk; kbclk is only ever sampled as data.
module ps2_frame_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_frame_rx_if.slave bus
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_kbclk_sync;
    logic [SYNC_STAGES-1:0] r_kbdat_sync;
    logic [FILT_W-1:0]      r_filt_cnt;
    logic                   r_filt_clk;
    logic                   r_filt_prev;
    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic [7:0]             r_shreg;
    logic                   r_par_ok;
    logic [TO_W-1:0]        r_to_cnt;
    logic [7:0]             r_code;
    logic                   r_code_valid;
    logic                   r_frame_err;
    logic [1:0]             r_err_type;
    logic                   r_busy;

    logic                   w_kbclk_s;
    logic                   w_bit;
    logic                   w_strobe;

    assign w_kbclk_s = r_kbclk_sync[SYNC_STAGES-1];
    assign w_bit     = r_kbdat_sync[SYNC_STAGES-1];
    assign w_strobe  = r_filt_prev & ~r_filt_clk;

    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.err_type   = r_err_type;
    assign bus.busy       = r_busy;

    // Pin synchronisers; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kbclk_sync <= '1;
            r_kbdat_sync <= '1;
        end else begin
            r_kbclk_sync <= {r_kbclk_sync[SYNC_STAGES-2:0], bus.kbclk};
            r_kbdat_sync <= {r_kbdat_sync[SYNC_STAGES-2:0], bus.kbdat};
        end
    end

    // Glitch filter: follow the synced kbclk only after FILTER_LEN equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt  <= '0;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (w_kbclk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                r_filt_clk <= w_kbclk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FILT_W'(1);
            end
        end
    end

    // Frame FSM with timeout; advances only on strobe, outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_shreg      <= 8'h00;
            r_par_ok     <= 1'b0;
            r_to_cnt     <= '0;
            r_code       <= 8'h00;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_type   <= 2'b00;
            r_busy       <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_strobe) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!w_bit) begin
                            r_state <= S_DATA;
                            r_cnt   <= 3'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shreg[r_cnt] <= w_bit;
                        r_cnt          <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shreg, w_bit};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        // A parity fault is reported even if the stop bit is also bad
                        if (!r_par_ok) begin
                            r_frame_err <= 1'b1;
                            r_err_type  <= 2'b01;
                        end else if (w_bit) begin
                            r_code       <= r_shreg;
                            r_code_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_type  <= 2'b10;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
                r_err_type  <= 2'b11;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: good frame, parity/stop/timeout faults,
// glitch rejection and mid-frame reset.
module tb_ps2_frame_rx;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // Pulse monitor state, sampled on the falling clk edge
    int   n_valid_pulses;
    int   n_valid_hi;
    int   n_err_pulses;
    int   n_err_hi;
    int   n_both;
    logic prev_valid;
    logic prev_err;

    ps2_frame_rx_if ps2_if ();

    ps2_frame_rx #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ps2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_valid_pulses = 0;
        n_valid_hi     = 0;
        n_err_pulses   = 0;
        n_err_hi       = 0;
        n_both         = 0;
        prev_valid     = 1'b0;
        prev_err       = 1'b0;
    end

    always @(negedge clk) begin
        if (ps2_if.code_valid === 1'b1) n_valid_hi++;
        if (ps2_if.code_valid === 1'b1 && prev_valid !== 1'b1) n_valid_pulses++;
        if (ps2_if.frame_err === 1'b1) n_err_hi++;
        if (ps2_if.frame_err === 1'b1 && prev_err !== 1'b1) n_err_pulses++;
        if (ps2_if.code_valid === 1'b1 && ps2_if.frame_err === 1'b1) n_both++;
        prev_valid = ps2_if.code_valid;
        prev_err   = ps2_if.frame_err;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while kbclk high, then kbclk low for half a period
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_if.kbdat = b;
        ps2_if.kbclk = 1'b1;
        cycles(20);
        ps2_if.kbclk = 1'b0;
        cycles(20);
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        ps2_if.kbclk = 1'b1;
        ps2_if.kbdat = 1'b1;
        cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        go_idle(40);
    endtask

    task automatic test_reset;
        ps2_if.kbclk = 1'b1;
        ps2_if.kbdat = 1'b1;
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if (ps2_if.code !== 8'h00 || ps2_if.code_valid !== 1'b0 || ps2_if.frame_err !== 1'b0 ||
            ps2_if.err_type !== 2'b00 || ps2_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: code=%h v=%b fe=%b et=%b busy=%b, want 00 0 0 00 0",
                     ps2_if.code, ps2_if.code_valid, ps2_if.frame_err, ps2_if.err_type, ps2_if.busy);
        end
        rst_n = 1'b1;
        cycles(10);
    endtask

    task automatic test_good_frame;
        int v0, e0;
        v0 = n_valid_pulses; e0 = n_err_pulses;
        send_bit(1'b0);
        checks++;
        if (ps2_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL good_busy_mid: busy=%b want 1", ps2_if.busy);
        end
        for (int i = 0; i < 8; i++) send_bit(i == 2 || i == 3 || i == 4);
        send_bit(1'b0);
        send_bit(1'b1);
        go_idle(40);
        checks++;
        if (ps2_if.code !== 8'h1C) begin
            errors++;
            $display("FAIL good_code: code=%h want 1c", ps2_if.code);
        end
        checks++;
        if (n_valid_pulses - v0 !== 1 || n_err_pulses - e0 !== 0) begin
            errors++;
            $display("FAIL good_pulses: valid=%0d err=%0d want 1 0", n_valid_pulses - v0, n_err_pulses - e0);
        end
        checks++;
        if (ps2_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL good_busy_end: busy=%b want 0", ps2_if.busy);
        end
    endtask

    task automatic test_parity_err;
        int v0, e0;
        v0 = n_valid_pulses; e0 = n_err_pulses;
        send_frame(8'hF0, 1'b0, 1'b1);
        checks++;
        if (n_err_pulses - e0 !== 1 || n_valid_pulses - v0 !== 0) begin
            errors++;
            $display("FAIL parity_pulses: err=%0d valid=%0d want 1 0", n_err_pulses - e0, n_valid_pulses - v0);
        end
        checks++;
        if (ps2_if.err_type !== 2'b01) begin
            errors++;
            $display("FAIL parity_type: err_type=%b want 01", ps2_if.err_type);
        end
        checks++;
        if (ps2_if.code !== 8'h1C) begin
            errors++;
            $display("FAIL parity_code_hold: code=%h want 1c", ps2_if.code);
        end
    endtask

    task automatic test_stop_err;
        int v0, e0;
        v0 = n_valid_pulses; e0 = n_err_pulses;
        send_frame(8'h5A, 1'b1, 1'b0);
        checks++;
        if (n_err_pulses - e0 !== 1 || n_valid_pulses - v0 !== 0) begin
            errors++;
            $display("FAIL stop_pulses: err=%0d valid=%0d want 1 0", n_err_pulses - e0, n_valid_pulses - v0);
        end
        checks++;
        if (ps2_if.err_type !== 2'b10 || ps2_if.code !== 8'h1C) begin
            errors++;
            $display("FAIL stop_type: err_type=%b code=%h want 10 1c", ps2_if.err_type, ps2_if.code);
        end
    endtask

    task automatic test_timeout;
        int v0, e0;
        v0 = n_valid_pulses; e0 = n_err_pulses;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        go_idle(250);
        checks++;
        if (n_err_pulses - e0 !== 1 || n_valid_pulses - v0 !== 0) begin
            errors++;
            $display("FAIL timeout_pulses: err=%0d valid=%0d want 1 0", n_err_pulses - e0, n_valid_pulses - v0);
        end
        checks++;
        if (ps2_if.err_type !== 2'b11 || ps2_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: err_type=%b busy=%b want 11 0", ps2_if.err_type, ps2_if.busy);
        end
        v0 = n_valid_pulses;
        send_frame(8'h12, 1'b1, 1'b1);
        checks++;
        if (ps2_if.code !== 8'h12 || n_valid_pulses - v0 !== 1) begin
            errors++;
            $display("FAIL timeout_recover: code=%h valid=%0d want 12 1", ps2_if.code, n_valid_pulses - v0);
        end
    endtask

    task automatic test_glitch;
        int v0, e0, busy_hits;
        v0 = n_valid_pulses; e0 = n_err_pulses; busy_hits = 0;
        @(negedge clk);
        ps2_if.kbdat = 1'b0;
        ps2_if.kbclk = 1'b0;
        cycles(2);
        ps2_if.kbclk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ps2_if.busy !== 1'b0) busy_hits++;
        end
        ps2_if.kbdat = 1'b1;
        checks++;
        if (busy_hits !== 0) begin
            errors++;
            $display("FAIL glitch_busy: busy high %0d cycles want 0", busy_hits);
        end
        checks++;
        if (n_valid_pulses - v0 !== 0 || n_err_pulses - e0 !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: valid=%0d err=%0d want 0 0", n_valid_pulses - v0, n_err_pulses - e0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        ps2_if.kbclk = 1'b1;
        ps2_if.kbdat = 1'b1;
        rst_n = 1'b0;
        v0 = n_valid_pulses; e0 = n_err_pulses;
        cycles(5);
        checks++;
        if (ps2_if.code !== 8'h00 || ps2_if.code_valid !== 1'b0 || ps2_if.frame_err !== 1'b0 ||
            ps2_if.err_type !== 2'b00 || ps2_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: code=%h v=%b fe=%b et=%b busy=%b, want 00 0 0 00 0",
                     ps2_if.code, ps2_if.code_valid, ps2_if.frame_err, ps2_if.err_type, ps2_if.busy);
        end
        rst_n = 1'b1;
        cycles(20);
        send_frame(8'h29, 1'b0, 1'b1);
        checks++;
        if (ps2_if.code !== 8'h29 || n_valid_pulses - v0 !== 1 || n_err_pulses - e0 !== 0) begin
            errors++;
            $display("FAIL midreset_resend: code=%h valid=%0d err=%0d want 29 1 0",
                     ps2_if.code, n_valid_pulses - v0, n_err_pulses - e0);
        end
        checks++;
        if (ps2_if.err_type !== 2'b00) begin
            errors++;
            $display("FAIL midreset_errtype: err_type=%b want 00", ps2_if.err_type);
        end
    endtask

    task automatic test_pulse_shape;
        checks++;
        if (n_valid_hi !== n_valid_pulses || n_err_hi !== n_err_pulses) begin
            errors++;
            $display("FAIL pulse_width: valid hi=%0d pulses=%0d err hi=%0d pulses=%0d",
                     n_valid_hi, n_valid_pulses, n_err_hi, n_err_pulses);
        end
        checks++;
        if (n_both !== 0) begin
            errors++;
            $display("FAIL pulse_exclusive: both high %0d cycles want 0", n_both);
        end
        checks++;
        if (n_valid_pulses !== 3 || n_err_pulses !== 3) begin
            errors++;
            $display("FAIL pulse_totals: valid=%0d err=%0d want 3 3", n_valid_pulses, n_err_pulses);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_pulse_shape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
